// File: rtl/byte_receiver_pkg.sv
//==============================================================================
// Module  : byte_receiver_pkg
// Brief   : Shared JTAG word constants and receiver state encoding.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package byte_receiver_pkg;

    localparam int JTAG_WORD_WIDTH = 32;
    localparam bit BIT_ORDER_MSB   = 1'b1;
    localparam bit BIT_ORDER_LSB   = 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_receiver.sv
//==============================================================================
// Module  : byte_receiver
// Brief   : Deserialises the Shift-DR TDI stream into WIDTH-bit words on a
//           valid/ready holding register with a sticky overrun flag.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module byte_receiver
    import byte_receiver_pkg::*;
#(
    parameter int WIDTH     = JTAG_WORD_WIDTH,
    parameter bit MSB_FIRST = BIT_ORDER_MSB,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk_tck,
    input  logic             reset,
    input  logic             enable,
    input  logic             tdi,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_one      = CW'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_shift;
    logic [WIDTH-1:0] w_sr_next;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_bit_count;
    logic [CW-1:0]    w_count_next;
    logic             r_valid;
    logic             r_overrun;
    logic             w_word_done;

    generate
        if (MSB_FIRST == BIT_ORDER_MSB) begin : g_msb_first
            assign w_sr_shift = {r_sr[WIDTH-2:0], tdi};
        end else if (MSB_FIRST == BIT_ORDER_LSB) begin : g_lsb_first
            assign w_sr_shift = {tdi, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // IDLE always holds a zero count, and WIDTH>=2 means a first bit can never complete a word.
    always_comb begin
        w_state_next = r_state;
        w_count_next = '0;
        w_sr_next    = '0;
        w_word_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_SHIFT;
                    w_count_next = c_one;
                    w_sr_next    = w_sr_shift;
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    w_sr_next = w_sr_shift;
                    if (r_bit_count == c_last_bit) begin
                        w_word_done  = 1'b1;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_bit_count + c_one;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_tck) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_bit_count <= '0;
            r_out       <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_sr_next;
            r_bit_count <= w_count_next;
            if (w_word_done) begin
                // A pending word the consumer is not taking this edge wins; the new one is lost.
                if (r_valid && !ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_out   <= w_sr_shift;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out       = r_out;
    assign valid     = r_valid;
    assign overrun   = r_overrun;
    assign bit_count = r_bit_count;

`ifdef FORMAL
    a_count_range: assert property (@(posedge clk_tck) r_bit_count < CW'(WIDTH));
    a_valid_hold:  assert property (@(posedge clk_tck) disable iff (reset)
                                    (r_valid && !ready) |=> r_valid);
    a_out_hold:    assert property (@(posedge clk_tck) disable iff (reset)
                                    (r_valid && !ready) |=> $stable(r_out));
    a_ovr_sticky:  assert property (@(posedge clk_tck) disable iff (reset)
                                    r_overrun |=> r_overrun);
`endif

endmodule

`default_nettype wire
